// File: rtl/note_hit_scanner.sv
// Object table with a two-stage pixel hit pipeline: per-slot rectangle compare,
// then priority encode of the lowest hit slot, plus sticky per-frame hit flags.
module note_hit_scanner #(
  parameter int N_OBJ     = 8,
  parameter int IDX_W     = 3,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int INCLUSIVE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_active,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic [X_W-1:0]   wr_w,
  input  logic [Y_W-1:0]   wr_h,
  input  logic             pix_valid,
  input  logic [X_W-1:0]   curr_x,
  input  logic [Y_W-1:0]   curr_y,
  input  logic             frame_start,
  output logic             hit_valid,
  output logic             hit_any,
  output logic [IDX_W-1:0] hit_idx,
  output logic [N_OBJ-1:0] hit_vec,
  output logic [N_OBJ-1:0] frame_hits,
  output logic [N_OBJ-1:0] frame_hits_last
);

  logic [N_OBJ-1:0] slot_active;
  logic [X_W-1:0]   slot_x [N_OBJ];
  logic [Y_W-1:0]   slot_y [N_OBJ];
  logic [X_W-1:0]   slot_w [N_OBJ];
  logic [Y_W-1:0]   slot_h [N_OBJ];

  logic [N_OBJ-1:0] cmp;
  logic [N_OBJ-1:0] s1_cmp;
  logic             s1_valid;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_active <= '0;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
        slot_w[i] <= '0;
        slot_h[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          slot_active[i] <= wr_active;
          slot_x[i]      <= wr_x;
          slot_y[i]      <= wr_y;
          slot_w[i]      <= wr_w;
          slot_h[i]      <= wr_h;
        end
      end
    end
  end

  // Far edges are widened by one bit so objects past the screen clip instead of wrapping.
  // x <= X+W-1 is rewritten as x < X+W, which is identical for W>=1 and cannot underflow.
  always_comb begin
    cmp = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      logic lo_x, lo_y, hi_x, hi_y;
      lo_x = (INCLUSIVE != 0) ? (curr_x >= slot_x[i]) : (curr_x > slot_x[i]);
      lo_y = (INCLUSIVE != 0) ? (curr_y >= slot_y[i]) : (curr_y > slot_y[i]);
      hi_x = {1'b0, curr_x} < ({1'b0, slot_x[i]} + {1'b0, slot_w[i]});
      hi_y = {1'b0, curr_y} < ({1'b0, slot_y[i]} + {1'b0, slot_h[i]});
      cmp[i] = slot_active[i] && (slot_w[i] != '0) && (slot_h[i] != '0)
               && lo_x && hi_x && lo_y && hi_y;
    end
  end

  always_comb begin
    enc_idx   = '0;
    enc_found = 1'b0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      if (s1_cmp[i] && !enc_found) begin
        enc_idx   = IDX_W'(i);
        enc_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_cmp    <= '0;
      hit_valid <= 1'b0;
      hit_any   <= 1'b0;
      hit_idx   <= '0;
      hit_vec   <= '0;
    end else begin
      s1_valid  <= pix_valid;
      s1_cmp    <= pix_valid ? cmp : '0;
      hit_valid <= s1_valid;
      hit_any   <= s1_valid && enc_found;
      hit_idx   <= s1_valid ? enc_idx : '0;
      hit_vec   <= s1_valid ? s1_cmp : '0;
    end
  end

  // hit_vec is already zero whenever hit_valid is low, so it can be OR'd in directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_hits      <= '0;
      frame_hits_last <= '0;
    end else if (frame_start) begin
      frame_hits_last <= frame_hits | hit_vec;
      frame_hits      <= '0;
    end else begin
      frame_hits      <= frame_hits | hit_vec;
    end
  end

endmodule

// File: tb/tb_note_hit_scanner.sv
// Directed bench for note_hit_scanner: strict and inclusive builds side by side.
module tb_note_hit_scanner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic       wr_active;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [9:0] wr_w;
  logic [8:0] wr_h;
  logic       pix_valid;
  logic [9:0] curr_x;
  logic [8:0] curr_y;
  logic       frame_start;

  logic       hv_s, ha_s, hv_i, ha_i;
  logic [2:0] hi_s, hi_i;
  logic [7:0] vec_s, fh_s, fl_s, vec_i, fh_i, fl_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  note_hit_scanner #(.N_OBJ(8), .IDX_W(3), .X_W(10), .Y_W(9), .INCLUSIVE(0)) dut_s (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_active(wr_active),
    .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h), .pix_valid(pix_valid),
    .curr_x(curr_x), .curr_y(curr_y), .frame_start(frame_start), .hit_valid(hv_s),
    .hit_any(ha_s), .hit_idx(hi_s), .hit_vec(vec_s), .frame_hits(fh_s), .frame_hits_last(fl_s)
  );

  note_hit_scanner #(.N_OBJ(8), .IDX_W(3), .X_W(10), .Y_W(9), .INCLUSIVE(1)) dut_i (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_active(wr_active),
    .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h), .pix_valid(pix_valid),
    .curr_x(curr_x), .curr_y(curr_y), .frame_start(frame_start), .hit_valid(hv_i),
    .hit_any(ha_i), .hit_idx(hi_i), .hit_vec(vec_i), .frame_hits(fh_i), .frame_hits_last(fl_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_slot(input logic [2:0] idx, input logic act, input logic [9:0] x,
                            input logic [8:0] y, input logic [9:0] w, input logic [8:0] h);
    wr_en = 1'b1; wr_idx = idx; wr_active = act;
    wr_x = x; wr_y = y; wr_w = w; wr_h = h;
    step();
    wr_en = 1'b0;
  endtask

  // One pixel followed by a bubble; returns when its result is on the outputs.
  task automatic scan(input logic [9:0] x, input logic [8:0] y);
    pix_valid = 1'b1; curr_x = x; curr_y = y;
    step();
    pix_valid = 1'b0;
    chk("latency_s", 32'(hv_s), 32'd0);
    step();
    chk("valid_s", 32'(hv_s), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_active = 1'b0;
    wr_x = '0; wr_y = '0; wr_w = '0; wr_h = '0;
    pix_valid = 1'b0; curr_x = '0; curr_y = '0; frame_start = 1'b0;
    step(); step();
    chk("rst_valid", 32'(hv_s), 32'd0);
    chk("rst_vec", 32'(vec_s), 32'd0);
    chk("rst_idx", 32'(hi_s), 32'd0);
    chk("rst_fh", 32'(fh_s), 32'd0);
    chk("rst_fl", 32'(fl_s), 32'd0);
    #2 reset_n = 1'b1;
    step();

    // Strict vs inclusive edges
    write_slot(3'd0, 1'b1, 10'd100, 9'd50, 10'd20, 9'd10);
    scan(10'd100, 9'd55); chk("s_left_edge", 32'(vec_s), 32'h00); chk("i_left_edge", 32'(vec_i), 32'h01);
    scan(10'd101, 9'd55); chk("s_inside", 32'(vec_s), 32'h01); chk("i_inside", 32'(vec_i), 32'h01);
    scan(10'd119, 9'd59); chk("s_far_in", 32'(vec_s), 32'h01); chk("i_far_in", 32'(vec_i), 32'h01);
    scan(10'd120, 9'd55); chk("s_right_edge", 32'(vec_s), 32'h00); chk("i_right_edge", 32'(vec_i), 32'h00);
    scan(10'd100, 9'd50); chk("s_corner", 32'(vec_s), 32'h00); chk("i_corner", 32'(vec_i), 32'h01);
    chk("i_corner_any", 32'(ha_i), 32'd1);
    scan(10'd120, 9'd50); chk("i_past_right", 32'(vec_i), 32'h00); chk("i_past_any", 32'(ha_i), 32'd0);

    // Zero-width slot
    write_slot(3'd4, 1'b1, 10'd10, 9'd10, 10'd0, 9'd5);
    scan(10'd10, 9'd12); chk("s_w0", 32'(vec_s), 32'h00); chk("i_w0", 32'(vec_i), 32'h00);

    // Priority
    write_slot(3'd2, 1'b1, 10'd290, 9'd190, 10'd20, 9'd20);
    write_slot(3'd5, 1'b1, 10'd295, 9'd195, 10'd10, 9'd10);
    scan(10'd300, 9'd200);
    chk("prio_vec", 32'(vec_s), 32'h24); chk("prio_idx", 32'(hi_s), 32'd2); chk("prio_any", 32'(ha_s), 32'd1);
    write_slot(3'd2, 1'b0, 10'd290, 9'd190, 10'd20, 9'd20);
    scan(10'd300, 9'd200);
    chk("prio2_vec", 32'(vec_s), 32'h20); chk("prio2_idx", 32'(hi_s), 32'd5);

    // Far-edge overflow
    write_slot(3'd1, 1'b1, 10'd1000, 9'd0, 10'd100, 9'd500);
    scan(10'd1023, 9'd250);
    chk("ovf_vec", 32'(vec_s), 32'h02); chk("ovf_idx", 32'(hi_s), 32'd1); chk("ovf_i", 32'(vec_i), 32'h02);
    scan(10'd5, 9'd250);
    chk("ovf_wrap_vec", 32'(vec_s), 32'h00); chk("ovf_wrap_any", 32'(ha_s), 32'd0);
    chk("ovf_wrap_idx", 32'(hi_s), 32'd0);

    // Write/scan race, back-to-back pixels
    write_slot(3'd0, 1'b0, 10'd100, 9'd50, 10'd20, 9'd10);
    wr_en = 1'b1; wr_idx = 3'd0; wr_active = 1'b1;
    wr_x = 10'd100; wr_y = 9'd50; wr_w = 10'd20; wr_h = 9'd10;
    pix_valid = 1'b1; curr_x = 10'd101; curr_y = 9'd55;
    step();
    wr_en = 1'b0;
    step();
    pix_valid = 1'b0;
    chk("race_old_valid", 32'(hv_s), 32'd1); chk("race_old_vec", 32'(vec_s), 32'h00);
    step();
    chk("race_new_valid", 32'(hv_s), 32'd1); chk("race_new_vec", 32'(vec_s), 32'h01);
    step();
    chk("bubble_valid", 32'(hv_s), 32'd0); chk("bubble_vec", 32'(vec_s), 32'h00);

    // Frame accounting
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("frame_clr", 32'(fh_s), 32'h00);
    write_slot(3'd3, 1'b1, 10'd500, 9'd300, 10'd10, 9'd10);
    scan(10'd101, 9'd55);
    scan(10'd505, 9'd305);
    pix_valid = 1'b1; curr_x = 10'd1010; curr_y = 9'd250;
    step();
    pix_valid = 1'b0;
    step();
    chk("frame_pre_vec", 32'(vec_s), 32'h02);
    chk("frame_pre_fh", 32'(fh_s), 32'h09);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("frame_last_s", 32'(fl_s), 32'h0B); chk("frame_hits_s", 32'(fh_s), 32'h00);
    chk("frame_last_i", 32'(fl_i), 32'h0B); chk("frame_hits_i", 32'(fh_i), 32'h00);

    // Result emerging right after frame_start lands in the new frame
    pix_valid = 1'b1; curr_x = 10'd101; curr_y = 9'd55;
    step();
    pix_valid = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("newframe_last", 32'(fl_s), 32'h00);
    step();
    chk("newframe_fh", 32'(fh_s), 32'h01);

    // Asynchronous reset mid-stream
    pix_valid = 1'b1; curr_x = 10'd101; curr_y = 9'd55;
    step(); step();
    chk("pre_rst_valid", 32'(hv_s), 32'd1); chk("pre_rst_vec", 32'(vec_s), 32'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(hv_s), 32'd0); chk("arst_vec", 32'(vec_s), 32'h00);
    chk("arst_any", 32'(ha_s), 32'd0); chk("arst_fh", 32'(fh_s), 32'h00);
    pix_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    pix_valid = 1'b1;
    step();
    chk("post_rst_lat", 32'(hv_s), 32'd0);
    step();
    pix_valid = 1'b0;
    chk("post_rst_valid", 32'(hv_s), 32'd1); chk("post_rst_any", 32'(ha_s), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
